rr_mux: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with round-robin arbitration and valid/ready handshakes on every input and on the output. It replaces fixed-select combinational muxing wherever several producers share one downstream consumer. Selection is made by a fair arbiter rather than an external select, and the result is held in a single output register stage that sustains one transfer per cycle.

---
 rtl/rr_mux.sv | 82 ++++++++
 tb/tb_rr_mux.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rr_mux.sv
// N-channel registered mux with round-robin arbitration and valid/ready on every port.
// Optional macro RR_MUX_CHAN_ID_EN adds the registered m_id output.
module rr_mux #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   s_valid,
    output logic [N-1:0]   s_ready,
    input  logic [N*W-1:0] s_data,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [W-1:0]   m_data
`ifdef RR_MUX_CHAN_ID_EN
    ,
    output logic [IDW-1:0] m_id
`endif
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] g;
    logic [IDW-1:0] ptr_next;
    logic           any;
    logic           load;
    logic [W-1:0]   sel_data;

    assign load = !m_valid || m_ready;

    // Search from ptr upwards, wrapping at N-1, and take the first valid channel.
    always_comb begin
        int idx;
        idx = 0;
        g   = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!any && s_valid[idx]) begin
                any = 1'b1;
                g   = IDW'(idx);
            end
        end
    end

    // Gated by rst_n so no channel sees a handshake while the block is held in reset.
    always_comb begin
        s_ready = '0;
        if (rst_n && load && any) s_ready[g] = 1'b1;
    end

    assign sel_data = s_data[int'(g)*W +: W];
    assign ptr_next = (g == IDW'(N-1)) ? '0 : g + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            ptr     <= '0;
        end else if (load) begin
            if (any) begin
                m_valid <= 1'b1;
                m_data  <= sel_data;
                ptr     <= ptr_next;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

`ifdef RR_MUX_CHAN_ID_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_id <= '0;
        end else if (load && any) begin
            m_id <= g;
        end
    end
`endif

endmodule

// File: tb/tb_rr_mux.sv
// Self-checking bench for rr_mux (N=4, W=8): vector table plus scoreboard queue,
// with hand-written reset sequences at start and mid-stream.
module tb_rr_mux;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   s_valid;
    logic [N-1:0]   s_ready;
    logic [N*W-1:0] s_data;
    logic           m_valid;
    logic           m_ready;
    logic [W-1:0]   m_data;
`ifdef RR_MUX_CHAN_ID_EN
    logic [1:0]     m_id;
`endif

    rr_mux #(.N(N), .W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
`ifdef RR_MUX_CHAN_ID_EN
        ,
        .m_id    (m_id)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic        mr;
        logic [3:0]  er;
        logic        emv;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] id;
    } exp_t;

    vec_t tbl[20];
    exp_t sb[$];
    exp_t e;
    logic [7:0] exp_md;
    logic [1:0] exp_id;
    int checks;
    int errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_out(input string name);
        check({name, " m_data"}, 32'(m_data), 32'(exp_md));
`ifdef RR_MUX_CHAN_ID_EN
        check({name, " m_id"}, 32'(m_id), 32'(exp_id));
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_md = 8'h00;
        exp_id = 2'd0;

        //            s_valid  s_data        m_ready s_ready  m_valid
        tbl[0]  = '{4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1};
        tbl[1]  = '{4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1};
        tbl[2]  = '{4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0100, 1'b1};
        tbl[3]  = '{4'b1111, 32'hA3A2A1A0, 1'b1, 4'b1000, 1'b1};
        tbl[4]  = '{4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1};
        // ch2 granted so the pointer sits at 3, then wrap and skip over 0101
        tbl[5]  = '{4'b0100, 32'hA3A2A1A0, 1'b1, 4'b0100, 1'b1};
        tbl[6]  = '{4'b0101, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1};
        tbl[7]  = '{4'b0101, 32'hA3A2A1A0, 1'b1, 4'b0100, 1'b1};
        tbl[8]  = '{4'b0101, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1};
        // load 55 from ch1, stall three cycles, then consume and reload on one edge
        tbl[9]  = '{4'b0010, 32'hA3A255A0, 1'b1, 4'b0010, 1'b1};
        tbl[10] = '{4'b1111, 32'hA3A2A1A0, 1'b0, 4'b0000, 1'b1};
        tbl[11] = '{4'b1111, 32'hA3A2A1A0, 1'b0, 4'b0000, 1'b1};
        tbl[12] = '{4'b1111, 32'hA3A2A1A0, 1'b0, 4'b0000, 1'b1};
        tbl[13] = '{4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0100, 1'b1};
        // single 3C transfer, then idle drain
        tbl[14] = '{4'b0010, 32'hA3A23CA0, 1'b1, 4'b0010, 1'b1};
        tbl[15] = '{4'b0000, 32'hA3A2A1A0, 1'b1, 4'b0000, 1'b0};
        tbl[16] = '{4'b0000, 32'hA3A2A1A0, 1'b1, 4'b0000, 1'b0};
        // empty register loads even with m_ready low, then holds
        tbl[17] = '{4'b1000, 32'hA3A2A1A0, 1'b0, 4'b1000, 1'b1};
        tbl[18] = '{4'b1000, 32'hA3A2A1A0, 1'b0, 4'b0000, 1'b1};
        tbl[19] = '{4'b0001, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1};

        rst_n   = 1'b1;
        s_valid = 4'b1111;
        s_data  = 32'hA3A2A1A0;
        m_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("reset m_valid", 32'(m_valid), 32'd0);
        check("reset m_data", 32'(m_data), 32'd0);
        check("reset s_ready", 32'(s_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset held s_ready", 32'(s_ready), 32'd0);
        check("reset held m_valid", 32'(m_valid), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_valid = tbl[i].v;
            s_data  = tbl[i].d;
            m_ready = tbl[i].mr;
            #1;
            check($sformatf("vec%0d s_ready", i), 32'(s_ready), 32'(tbl[i].er));
            for (int c = 0; c < N; c++) begin
                if (tbl[i].er[c]) begin
                    e.data = tbl[i].d[c*8 +: 8];
                    e.id   = 2'(c);
                    sb.push_back(e);
                end
            end
            @(posedge clk);
            #1;
            check($sformatf("vec%0d m_valid", i), 32'(m_valid), 32'(tbl[i].emv));
            if (m_valid && sb.size() != 0) begin
                e = sb.pop_front();
                exp_md = e.data;
                exp_id = e.id;
            end
            check_out($sformatf("vec%0d", i));
            @(negedge clk);
        end
        check("scoreboard empty", 32'(sb.size()), 32'd0);

        // Reach ptr=2 with m_valid=1, then reset mid-stream
        s_valid = 4'b0010;
        s_data  = 32'hA3A2A1A0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_md = 8'hA1;
        exp_id = 2'd1;
        check("pre-reset m_valid", 32'(m_valid), 32'd1);
        check_out("pre-reset");
        @(negedge clk);
        m_ready = 1'b0;
        s_valid = 4'b1010;
        rst_n   = 1'b0;
        #1;
        sb.delete();
        exp_md = 8'h00;
        exp_id = 2'd0;
        check("midreset m_valid", 32'(m_valid), 32'd0);
        check("midreset s_ready", 32'(s_ready), 32'd0);
        check_out("midreset");
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        #1;
        check("post-reset s_ready", 32'(s_ready), 32'b0010);
        @(posedge clk);
        #1;
        exp_md = 8'hA1;
        exp_id = 2'd1;
        check("post-reset m_valid", 32'(m_valid), 32'd1);
        check_out("post-reset");
        @(negedge clk);
        #1;
        check("post-reset next s_ready", 32'(s_ready), 32'b1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
